// File: rtl/upower_pkg.sv
// Shared uPower pipeline definitions: default widths, reset PC and the
// state encoding used by the fetch-stage PC logic.
package upower_pkg;

  localparam int          XLEN_DEF     = 64;
  localparam int          PC_INC_DEF   = 4;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;

  typedef enum logic {
    BOOT,
    RUN
  } pc_state_e;

endpackage

// File: rtl/prio_sel.sv
// Generic priority selector: finds the lowest-index asserted request and
// returns its index and its slice of the packed target bus.
module prio_sel
  import upower_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int XLEN = XLEN_DEF,
  parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0]      valid,
  input  logic [NSRC*XLEN-1:0] targets,
  output logic                 any,
  output logic [IW-1:0]        idx,
  output logic [XLEN-1:0]      target
);

  // Walk from the lowest priority upward so index 0 is the last writer.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    target = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (valid[i]) begin
        any    = 1'b1;
        idx    = IW'(i);
        target = targets[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Fetch-stage program counter: prioritised redirects, sequential increment,
// stall hold, and buffering of a redirect that arrives while stalled.
module pc_next_unit
  import upower_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              NSRC     = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              INC      = PC_INC_DEF,
  localparam int             SW       = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NSRC-1:0]      redir_valid,
  input  logic [NSRC*XLEN-1:0] redir_pc,
  output logic [XLEN-1:0]      pc,
  output logic                 pc_valid,
  output logic                 flush,
  output logic [SW-1:0]        flush_src,
  output logic                 pend
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pend_pc;
  logic [SW-1:0]   pend_src;

  logic            new_any;
  logic [SW-1:0]   new_idx;
  logic [XLEN-1:0] new_pc;

  logic            win_any;
  logic [SW-1:0]   win_idx;
  logic [XLEN-1:0] win_pc;
  logic            hold;

  prio_sel #(
    .NSRC (NSRC),
    .XLEN (XLEN),
    .IW   (SW)
  ) u_prio_sel (
    .valid   (redir_valid),
    .targets (redir_pc),
    .any     (new_any),
    .idx     (new_idx),
    .target  (new_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // A buffered redirect only beats a new one when strictly higher priority;
  // on equal index the fresh target is the more recent and wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    win_any = new_any | pend;
    win_idx = new_idx;
    win_pc  = new_pc;
    if (pend && (!new_any || (pend_src < new_idx))) begin
      win_idx = pend_src;
      win_pc  = pend_pc;
    end

    hold = (state_q == BOOT) || stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      pc_valid  <= 1'b0;
      flush     <= 1'b0;
      flush_src <= '0;
      pend      <= 1'b0;
      pend_pc   <= '0;
      pend_src  <= '0;
    end else begin
      pc_valid <= 1'b1;
      flush    <= 1'b0;
      if (hold) begin
        if (win_any) begin
          pend     <= 1'b1;
          pend_pc  <= win_pc;
          pend_src <= win_idx;
        end
      end else if (win_any) begin
        pc        <= win_pc;
        flush     <= 1'b1;
        flush_src <= win_idx;
        pend      <= 1'b0;
      end else begin
        pc <= pc + XLEN'(INC);
      end
    end
  end

endmodule
